// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES-128/192/256 key schedule writing one
// word per cycle into a round-key store with a registered read port.
module aes_key_expand_seq #(
   parameter int NK_MAX = 8,
   parameter int NR_MAX = NK_MAX + 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [1:0]             key_len,
   input  logic [32*NK_MAX-1:0]   key,
   input  logic [3:0]             rd_round,
   output logic                   busy,
   output logic                   done,
   output logic                   ready,
   output logic                   err,
   output logic [127:0]           rd_key
);
   localparam int NW = 4 * (NR_MAX + 1);
   localparam int IW = 6;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND} state_t;
   state_t state_q, state_d;

   logic [3:0]    nk_q, nk_d, nr_q, nr_d, nk_req;
   logic          req_ok;
   logic [IW-1:0] i_q, i_d, last_w, rd_base;
   logic [2:0]    pos_q, pos_d;
   logic [7:0]    rcon_q, rcon_d, rcon_nx;
   logic          done_q, done_d, ready_q, ready_d, err_q, err_d;
   logic [127:0]  rd_key_q;
   logic [31:0]   w_q [NW];
   logic [31:0]   w_prev, w_back, w_tmp, w_new;

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p, aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as x^254 in GF(2^8) followed by the affine map
   function automatic logic [7:0] sbox(logic [7:0] x);
      logic [7:0] p, r;
      p = x;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
               ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   always_comb begin
      nk_req = 4'd0;
      unique case (key_len)
         2'd0:    nk_req = 4'd4;
         2'd1:    nk_req = 4'd6;
         2'd2:    nk_req = 4'd8;
         default: nk_req = 4'd0;
      endcase
      req_ok = (nk_req != 4'd0) && (int'(nk_req) <= NK_MAX);
   end

   assign last_w  = {nr_q, 2'b11};
   assign rcon_nx = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   always_comb begin
      w_prev = w_q[i_q - 6'd1];
      w_back = w_q[i_q - {2'b00, nk_q}];
      w_tmp  = w_prev;
      unique case (1'b1)
         (pos_q == 3'd0):
            w_tmp = subword({w_prev[7:0], w_prev[31:8]}) ^ {24'h0, rcon_q};
         (nk_q == 4'd8 && pos_q == 3'd4):
            w_tmp = subword(w_prev);
         default:
            w_tmp = w_prev;
      endcase
      w_new = w_back ^ w_tmp;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start && req_ok) state_d = S_LOAD;
         S_LOAD:   state_d = S_EXPAND;
         S_EXPAND: if (i_q == last_w) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      done_d  = 1'b0;
      ready_d = ready_q;
      err_d   = err_q;
      nk_d    = nk_q;
      nr_d    = nr_q;
      i_d     = i_q;
      pos_d   = pos_q;
      rcon_d  = rcon_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ready_d = 1'b0;
               err_d   = !req_ok;
               if (req_ok) begin
                  nk_d = nk_req;
                  nr_d = nk_req + 4'd6;
               end
            end
         end
         S_LOAD: begin
            i_d    = {2'b00, nk_q};
            pos_d  = 3'd0;
            rcon_d = 8'h01;
         end
         S_EXPAND: begin
            i_d   = i_q + 6'd1;
            pos_d = ({1'b0, pos_q} == nk_q - 4'd1) ? 3'd0 : pos_q + 3'd1;
            if (pos_q == 3'd0) rcon_d = rcon_nx;
            if (i_q == last_w) begin
               done_d  = 1'b1;
               ready_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         nk_q    <= 4'd4;
         nr_q    <= 4'd0;
         i_q     <= '0;
         pos_q   <= 3'd0;
         rcon_q  <= 8'h01;
      end else begin
         done_q  <= done_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         nk_q    <= nk_d;
         nr_q    <= nr_d;
         i_q     <= i_d;
         pos_q   <= pos_d;
         rcon_q  <= rcon_d;
      end
   end

   // Key store needs no reset; ready qualifies its contents
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD) begin
         for (int j = 0; j < NK_MAX; j++)
            if (j < int'(nk_q)) w_q[j] <= key[32*j +: 32];
      end else if (state_q == S_EXPAND) begin
         w_q[i_q] <= w_new;
      end
   end

   assign rd_base = {rd_round, 2'b00};

   always_ff @(posedge clk) begin
      if (!rst_n)                rd_key_q <= '0;
      else if (rd_round > nr_q)  rd_key_q <= '0;
      else rd_key_q <= {w_q[rd_base + 6'd3], w_q[rd_base + 6'd2],
                        w_q[rd_base + 6'd1], w_q[rd_base]};
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign ready  = ready_q;
   assign err    = err_q;
   assign rd_key = rd_key_q;
endmodule

// File: doc/aes_key_expand_seq.md
AES_KEY_EXPAND_SEQ -- requirements
Module: aes_key_expand_seq

Interface
REQ-001 SHALL have parameter NK_MAX, default 8, giving the largest supported key length in 32-bit words (4, 6 or 8).
REQ-002 SHALL have parameter NR_MAX, default NK_MAX+6, giving the largest round count and the round-key store depth NR_MAX+1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to expand key; sampled only in IDLE.
REQ-006 SHALL have port key_len, input, 2 bits: 0 = AES-128 (Nk=4), 1 = AES-192 (Nk=6), 2 = AES-256 (Nk=8), 3 = illegal.
REQ-007 SHALL have port key, input, 32*NK_MAX bits: key word i = key[32i+:32], byte 0 of each word in bits [7:0]; unused upper words ignored.
REQ-008 SHALL have port rd_round, input, 4 bits: round-key index to read.
REQ-009 SHALL have port busy, output, 1 bit: expansion in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the schedule completes.
REQ-011 SHALL have port ready, output, 1 bit: the stored schedule is complete and valid.
REQ-012 SHALL have port err, output, 1 bit: the last start carried an illegal or unsupported key_len.
REQ-013 SHALL have port rd_key, output, 128 bits: round key {w[4r+3], w[4r+2], w[4r+1], w[4r]} for r = the registered rd_round.

Function
REQ-014 SHALL implement a three-state FSM:
- IDLE -> LOAD on start.
- LOAD -> EXPAND after one cycle.
- EXPAND -> IDLE after the last word is written.
REQ-015 SHALL handle start in IDLE with key_len=3, or with Nk>NK_MAX, as follows: stay in IDLE, set err=1 and ready=0, and leave the store unchanged.
REQ-016 SHALL handle a legal start in IDLE as follows:
- latch Nk and Nr=Nk+6;
- set err=0 and ready=0;
- assert busy from the next cycle.
REQ-017 SHALL, in the LOAD cycle, write w[0..Nk-1] from key, set word index i=Nk, and set rcon=8'h01.
REQ-018 SHALL, in EXPAND, compute and write exactly one word w[i] per cycle:
- if i mod Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {24'h0, rcon}, then rcon = xtime(rcon);
- else if Nk==8 and i mod Nk == 4: w[i] = w[i-Nk] ^ SubWord(w[i-1]);
- else: w[i] = w[i-Nk] ^ w[i-1].
REQ-019 SHALL define RotWord(w) = {w[7:0], w[31:8]}, and SubWord as the team AES S-box applied to each byte.
REQ-020 SHALL define xtime as a left shift, XORed with 8'h1b when bit 7 was set; the rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
REQ-021 SHALL track the i mod Nk position with a wrapping counter, not a divider.
REQ-022 SHALL end EXPAND after writing w[4*Nr+3]. That is 40 / 46 / 52 EXPAND cycles for Nk = 4 / 6 / 8.
REQ-023 SHALL, in the cycle after the last write: assert done for exactly one cycle, set ready=1, drop busy, and return to IDLE.
REQ-024 SHALL give a start-to-done latency of 42 / 48 / 54 cycles for Nk = 4 / 6 / 8, counted from the start-sample edge to the done-high edge.
REQ-025 SHALL ignore start while busy=1, with no restart and no error.
REQ-026 SHALL accept start in the same cycle that done is high: the FSM is in IDLE, the new expansion begins, and ready returns to 0.
REQ-027 SHALL register rd_key one cycle after rd_round is sampled.
REQ-028 SHALL return all zeros on rd_key when rd_round > the latched Nr.
REQ-029 SHALL return current store contents on rd_key while ready=0; that data is undefined to users.

Reset
REQ-030 SHALL, while rst_n=0 at a rising clk edge, force:
- FSM to IDLE;
- busy=0, done=0, ready=0, err=0;
- rd_key=0, rcon=8'h01, word index 0.
REQ-031 SHALL abort any in-progress expansion when reset is applied mid-operation, leaving ready=0 and producing no done pulse.
REQ-032 SHALL not require the key store to be reset.

Verification
REQ-033 SHALL cover AES-128 with key=128'h3c4fcf098815f7aba6d2ae2816157e2b:
- done exactly 42 cycles after start;
- rd_round=10 -> rd_key=128'ha60c63b6c80c3fe18925eec9a8f914d0;
- rd_round=0 -> rd_key equals the key input.
REQ-034 SHALL cover AES-256 with the FIPS-197 key 603deb10...0914dff4, byte-packed per REQ-007:
- done after 54 cycles;
- rd_round=14 -> rd_key=128'h1e636c7044f36d040b8d18e6d19048fe.
REQ-035 SHALL cover AES-192 with the FIPS-197 key 8e73b0f7...522c6b7b:
- done after 48 cycles;
- rd_round=12 matches the FIPS words w[48..51], byte-reversed per word;
- rd_round=13 -> rd_key=0.
REQ-036 SHALL cover key_len=3 with start:
- err=1, busy stays 0, no done pulse, ready=0;
- a following legal start clears err.
REQ-037 SHALL cover rst_n=0 applied at EXPAND cycle 20: no done pulse, ready=0, busy=0 on the next cycle. A fresh start afterwards completes with correct keys.
REQ-038 SHALL cover start pulses during busy being ignored (latency unchanged), and start in the done cycle launching a second expansion with ready falling to 0.
